// File: rtl/fetch_ifu.sv
// Instruction fetch unit: issues sequential word fetches to imem and buffers the returned words for decode.
// Latency: a response in cycle N is visible on instr_de0/pc_de0 in cycle N+1 (registered buffer write, no bypass).
// Backpressure: stall_de0 holds the head entry. Requests are credit-limited so every live response has a buffer slot.
//
// Ports:
//   clk, reset (async, active-low)
//   redirect_valid/redirect_pc                     : flush and restart fetch at redirect_pc
//   imem_req_valid/ready/addr                      : in-order fetch request channel
//   imem_rsp_valid/data                            : in-order response channel (no backpressure)
//   instr_valid_de0/instr_de0/pc_de0, stall_de0    : decode handshake

// Small generic FIFO. The head entry is read combinationally from storage.
module fetch_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  logic [W-1:0]                 push_dat,
   input  logic                         pop,
   output logic [W-1:0]                 head_dat,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_dat;
   end

   assign head_dat = mem[rd_ptr];
   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
endmodule

module fetch_ifu #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          FIFO_DEPTH      = 4,
   parameter int          MAX_OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid_de0,
   output logic [31:0] instr_de0,
   output logic [31:0] pc_de0,
   input  logic        stall_de0
);
   localparam int OW = $clog2(MAX_OUTSTANDING+1);
   localparam int CW = $clog2(FIFO_DEPTH+1);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_ent_t;

   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;
   logic [31:0]   redirect_pc_al;
   logic [OW-1:0] outstanding;
   logic [OW-1:0] outstanding_nxt;
   logic [OW-1:0] drop_cnt;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty;
   logic          fifo_full;
   logic          req_fire;
   logic          push;
   logic          pop;
   logic          credit_ok;
   fetch_ent_t    push_ent;
   fetch_ent_t    head_ent;
   fetch_ent_t    last_q;

   assign redirect_pc_al = redirect_pc & 32'hFFFF_FFFC;

   // Credit counts only live requests (not ones already doomed to be dropped)
   // plus buffered entries, so every live response is guaranteed a slot.
   assign credit_ok = (int'(outstanding) - int'(drop_cnt) + int'(fifo_count)) < FIFO_DEPTH;

   // Gated by reset so the request drops the instant reset asserts.
   assign imem_req_valid = reset && !redirect_valid &&
                           (int'(outstanding) < MAX_OUTSTANDING) && credit_ok;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign outstanding_nxt = outstanding + OW'(req_fire) - OW'(imem_rsp_valid);

   // A response is kept only if it belongs to the current fetch stream.
   assign push     = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
   assign pop      = !fifo_empty && !stall_de0 && !redirect_valid;
   assign push_ent = '{instr: imem_rsp_data, pc: rsp_pc};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old stream.
            fetch_pc <= redirect_pc_al;
            rsp_pc   <= redirect_pc_al;
            drop_cnt <= outstanding_nxt;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (push)     rsp_pc   <= rsp_pc + 32'd4;
            if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
         end
      end
   end

   fetch_fifo #(
      .W     ($bits(fetch_ent_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_buf (
      .clk      (clk),
      .reset    (reset),
      .flush    (redirect_valid),
      .push     (push),
      .push_dat (push_ent),
      .pop      (pop),
      .head_dat (head_ent),
      .empty    (fifo_empty),
      .full     (fifo_full),
      .count    (fifo_count)
   );

   // Remembers the last presented entry so the decode outputs keep their
   // value once the buffer drains or is flushed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)           last_q <= '0;
      else if (!fifo_empty) last_q <= head_ent;
   end

   assign instr_valid_de0 = !fifo_empty;
   assign instr_de0       = fifo_empty ? last_q.instr : head_ent.instr;
   assign pc_de0          = fifo_empty ? last_q.pc    : head_ent.pc;

   // The credit scheme makes a push into a full buffer unreachable.
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full));
endmodule

// File: tb/tb_fetch_ifu.sv
module tb_fetch_ifu;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] KEY    = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        instr_valid_de0;
   logic [31:0] instr_de0;
   logic [31:0] pc_de0;
   logic        stall_de0 = 1'b0;

   always #5 clk = ~clk;

   fetch_ifu #(.RESET_PC(RST_PC), .FIFO_DEPTH(4), .MAX_OUTSTANDING(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_data   (imem_rsp_data),
      .instr_valid_de0 (instr_valid_de0),
      .instr_de0       (instr_de0),
      .pc_de0          (pc_de0),
      .stall_de0       (stall_de0)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   typedef struct {
      logic [31:0] redir_pc;
      int          n_out;
      logic [31:0] p0;
      logic [31:0] p1;
      logic [31:0] p2;
   } vec_t;

   exp_t        exp_q[$];
   logic [31:0] mem_q[$];
   logic [31:0] pop_log[$];
   logic [31:0] exp_next_pc = RST_PC;
   int n_vec = 0, n_err = 0;
   int ready_pct = 100, rsp_pct = 100, stall_pct = 0;
   int hs_cnt = 0, push_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // One clock: sample/score at negedge, drive next-cycle inputs 1 unit after posedge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (!reset) begin
         exp_q.delete();
         mem_q.delete();
         exp_next_pc = RST_PC;
      end else if (redirect_valid) begin
         chk("no_req_in_redirect", 32'(imem_req_valid), 32'd0);
         exp_q.delete();
         exp_next_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
         if (instr_valid_de0 && !stall_de0) begin
            if (exp_q.size() == 0) chk("spurious_instr_valid", 32'(instr_valid_de0), 32'd0);
            else begin
               e = exp_q.pop_front();
               chk("pc_de0", pc_de0, e.pc);
               chk("instr_de0", instr_de0, e.instr);
               pop_log.push_back(pc_de0);
            end
         end
         if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_next_pc);
            e.pc    = exp_next_pc;
            e.instr = exp_next_pc ^ KEY;
            exp_q.push_back(e);
            mem_q.push_back(imem_req_addr);
            exp_next_pc = exp_next_pc + 32'd4;
            hs_cnt++;
         end
      end
      if (reset && imem_rsp_valid) push_cnt++;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      if (!reset) begin
         imem_rsp_valid = 1'b0;
         mem_q.delete();
      end else if (mem_q.size() > 0 && int'($urandom_range(99)) < rsp_pct) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_q.pop_front() ^ KEY;
      end else begin
         imem_rsp_valid = 1'b0;
      end
      imem_req_ready = (int'($urandom_range(99)) < ready_pct);
      stall_de0      = (int'($urandom_range(99)) < stall_pct);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   vec_t vecs[4];

   initial begin
      int n, base;
      bit found;

      vecs[0] = '{redir_pc: 32'h0000_0100, n_out: 3, p0: 32'h0000_0100, p1: 32'h0000_0104, p2: 32'h0000_0108};
      vecs[1] = '{redir_pc: 32'hFFFF_FFF8, n_out: 1, p0: 32'hFFFF_FFF8, p1: 32'hFFFF_FFFC, p2: 32'h0000_0000};
      vecs[2] = '{redir_pc: 32'h0000_0203, n_out: 4, p0: 32'h0000_0200, p1: 32'h0000_0204, p2: 32'h0000_0208};
      vecs[3] = '{redir_pc: 32'h0000_1000, n_out: 0, p0: 32'h0000_1000, p1: 32'h0000_1004, p2: 32'h0000_1008};

      // Reset state
      #1 reset = 1'b0;
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid_de0), 32'd0);
      chk("rst_instr", instr_de0, 32'd0);
      chk("rst_pc", pc_de0, 32'd0);

      // Basic stream
      ready_pct = 100; rsp_pct = 100; stall_pct = 0;
      do_reset();
      n = 0;
      while (!instr_valid_de0 && n < 8) begin tick(); n++; end
      chk("startup_latency", 32'(n), 32'd2);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("stream_valid", 32'(instr_valid_de0), 32'd1);
      end

      // Backpressure: head frozen, requests stop at 4 in flight+buffered
      stall_pct = 100;
      stall_de0 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall_valid", 32'(instr_valid_de0), 32'd1);
         if (exp_q.size() > 0) begin
            chk("stall_pc_held", pc_de0, exp_q[0].pc);
            chk("stall_instr_held", instr_de0, exp_q[0].instr);
         end
         chk("stall_credit", 32'(exp_q.size() <= 4), 32'd1);
      end
      chk("stall_inflight", 32'(exp_q.size()), 32'd4);
      chk("stall_req_off", 32'(imem_req_valid), 32'd0);
      stall_pct = 0;
      stall_de0 = 1'b0;
      for (int i = 0; i < 20; i++) tick();

      // Redirect table
      foreach (vecs[k]) begin
         ready_pct = 100; rsp_pct = 0; stall_pct = 0;
         do_reset();
         base = hs_cnt;
         n = 0;
         while (hs_cnt - base < vecs[k].n_out && n < 10) begin tick(); n++; end
         chk("redir_setup_outstanding", 32'(hs_cnt - base), 32'(vecs[k].n_out));
         ready_pct = 100; rsp_pct = 100;
         pop_log.delete();
         redirect_valid = 1'b1;
         redirect_pc    = vecs[k].redir_pc;
         tick();
         chk("redir_flush_valid", 32'(instr_valid_de0), 32'd0);
         n = 0;
         while (pop_log.size() < 3 && n < 40) begin tick(); n++; end
         if (pop_log.size() < 3) timeout("redir_first_pops");
         else begin
            chk("redir_pc0", pop_log[0], vecs[k].p0);
            chk("redir_pc1", pop_log[1], vecs[k].p1);
            chk("redir_pc2", pop_log[2], vecs[k].p2);
         end
      end

      // Redirect coincident with a response and a pop, more still in flight
      ready_pct = 100; rsp_pct = 50; stall_pct = 0;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         if (imem_rsp_valid && instr_valid_de0 && !stall_de0 && mem_q.size() > 0) found = 1'b1;
      end
      if (!found) timeout("coincident_setup");
      else begin
         pop_log.delete();
         redirect_valid = 1'b1;
         redirect_pc    = 32'h0000_4000;
         tick();
         chk("coinc_flush_valid", 32'(instr_valid_de0), 32'd0);
         rsp_pct = 100;
         n = 0;
         while (pop_log.size() < 2 && n < 40) begin tick(); n++; end
         if (pop_log.size() < 2) timeout("coinc_pops");
         else begin
            chk("coinc_pc0", pop_log[0], 32'h0000_4000);
            chk("coinc_pc1", pop_log[1], 32'h0000_4004);
         end
      end

      // Async reset mid-stream with 3 buffered entries
      ready_pct = 100; rsp_pct = 100; stall_pct = 100;
      do_reset();
      stall_de0 = 1'b1;
      base = push_cnt;
      n = 0;
      while (push_cnt - base < 3 && n < 20) begin tick(); n++; end
      chk("areset_fill_valid", 32'(instr_valid_de0), 32'd1);
      chk("areset_fill_pc", pc_de0, RST_PC);
      #2 reset = 1'b0;
      #1;
      chk("areset_instr_valid", 32'(instr_valid_de0), 32'd0);
      chk("areset_req_valid", 32'(imem_req_valid), 32'd0);
      chk("areset_pc", pc_de0, 32'd0);
      imem_rsp_valid = 1'b0;
      mem_q.delete();
      exp_q.delete();
      exp_next_pc = RST_PC;
      tick();
      tick();
      reset = 1'b1;
      stall_pct = 0;
      stall_de0 = 1'b0;
      pop_log.delete();
      n = 0;
      while (pop_log.size() < 2 && n < 20) begin tick(); n++; end
      if (pop_log.size() < 2) timeout("areset_restart");
      else begin
         chk("areset_restart_pc0", pop_log[0], RST_PC);
         chk("areset_restart_pc1", pop_log[1], RST_PC + 32'd4);
      end

      // Random traffic with periodic redirects; scoreboard checks every pop
      ready_pct = 70; rsp_pct = 60; stall_pct = 30;
      for (int i = 0; i < 300; i++) begin
         if (i % 37 == 36) begin
            redirect_valid = 1'b1;
            redirect_pc    = $urandom();
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
